// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: feeder FSM states, default
// character width and frame bit-select codes used by the TX FSM.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

    localparam logic [1:0] FRAME_SEL_START  = 2'd0;
    localparam logic [1:0] FRAME_SEL_DATA   = 2'd1;
    localparam logic [1:0] FRAME_SEL_PARITY = 2'd2;
    localparam logic [1:0] FRAME_SEL_STOP   = 2'd3;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bus between the system side / TX FSM and the TX feeder.
// slave = feeder side, master = system + TX FSM side.
interface uart_tx_feeder_if
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  FULL;
    logic                  EMPTY;
    logic                  OVF;
    logic                  TX_BUSY;
    logic                  TX_DATA_VALID;
    logic [DATA_WIDTH-1:0] TX_P_DATA;

    modport slave (
        input  WR_EN, WR_DATA, TX_BUSY,
        output FULL, EMPTY, OVF,
        output TX_DATA_VALID, TX_P_DATA
    );

    modport master (
        output WR_EN, WR_DATA, TX_BUSY,
        input  FULL, EMPTY, OVF,
        input  TX_DATA_VALID, TX_P_DATA
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the TX feeder: storage, pointers, count, flags.
// Exposes count only when UART_TX_FEEDER_LEVEL_EN is defined.
module uart_sync_fifo
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    output logic [ADDR_W:0]       count
`endif
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       cnt;
    logic                  push;
    logic                  do_pop;

    assign full    = (cnt == (ADDR_W+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push    = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign count = cnt;
`endif

    // storage write; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointers, occupancy count and overflow pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf <= wr_en && !push;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// TX feeder: buffers bytes and launches one per frame, paced by TX_BUSY.
// Optional FIFO_LEVEL output enabled by UART_TX_FEEDER_LEVEL_EN.
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_feeder_if.slave  bus
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    output logic [ADDR_W:0]  FIFO_LEVEL
`endif
);

    feeder_state_t         state;
    logic                  pop;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] p_data;
    logic [DATA_WIDTH-1:0] rd_data;

    // pop only when the transmitter is free and a byte is waiting
    assign pop = (state == IDLE) && !bus.EMPTY && !bus.TX_BUSY;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (bus.WR_EN),
        .wr_data (bus.WR_DATA),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (bus.FULL),
        .empty   (bus.EMPTY),
        .ovf     (bus.OVF)
`ifdef UART_TX_FEEDER_LEVEL_EN
        ,
        .count   (FIFO_LEVEL)
`endif
    );

    assign bus.TX_DATA_VALID = tx_valid;
    assign bus.TX_P_DATA     = p_data;

    // launch FSM with registered valid pulse and held parallel data
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            p_data   <= '0;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        p_data   <= rd_data;
                        tx_valid <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD:      state <= WAIT_ACK;
                WAIT_ACK:  if (bus.TX_BUSY) state <= WAIT_DONE;
                WAIT_DONE: if (!bus.TX_BUSY) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
